// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared memory port between instruction fetch and load/store, with a tagged 2-cycle read-return pipeline.
// Optional feature: define MEM_ARB_RR_EN for round-robin conflict resolution (default build is fixed data-over-fetch priority).
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_r_w,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    localparam logic [3:0] WAIT_MAX_C = 4'(WAIT_MAX);

    logic [3:0]        starv_cnt_r;
    logic              fetch_force_s;
    logic              if_gnt_s;
    logic              d_gnt_s;
    logic              mem_r_w_s;
    logic [ADDR_W-1:0] mem_address_s;
    logic [DATA_W-1:0] mem_in_s;
    owner_e            s1_owner_r;
    logic              s1_read_r;
    logic              if_rvalid_r;
    logic              d_rvalid_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
`ifdef MEM_ARB_RR_EN
    logic              rr_ptr_r;    // 0: data preferred, 1: fetch preferred
`endif

    assign fetch_force_s = (starv_cnt_r == WAIT_MAX_C);

    // Grant selection; reset low suppresses every grant
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (!reset) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (fetch_force_s && if_req) begin
            if_gnt_s = 1'b1;
        end else if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (rr_ptr_r) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
`else
            d_gnt_s = 1'b1;
`endif
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // Memory port mirrors whichever request won; fetch is always a read with zero write data
    always_comb begin
        mem_r_w_s     = 1'b0;
        mem_address_s = {ADDR_W{1'b0}};
        mem_in_s      = {DATA_W{1'b0}};
        if (if_gnt_s) begin
            mem_address_s = if_addr;
        end else if (d_gnt_s) begin
            mem_r_w_s     = d_we;
            mem_address_s = d_addr;
            mem_in_s      = d_wdata;
        end else begin
            mem_r_w_s     = 1'b0;
        end
    end

    // Starvation counter: counts consecutive denied fetch cycles, saturating at the threshold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starv_cnt_r <= 4'd0;
        end else if (!if_req || if_gnt_s) begin
            starv_cnt_r <= 4'd0;
        end else if (starv_cnt_r != WAIT_MAX_C) begin
            starv_cnt_r <= starv_cnt_r + 4'd1;
        end else begin
            starv_cnt_r <= starv_cnt_r;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer: after any grant the other requester becomes preferred
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= 1'b0;
        end else if (if_gnt_s) begin
            rr_ptr_r <= 1'b0;
        end else if (d_gnt_s) begin
            rr_ptr_r <= 1'b1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Stage 1: remember who owns the access in flight and whether data comes back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_owner_r <= OWN_NONE;
            s1_read_r  <= 1'b0;
        end else if (if_gnt_s) begin
            s1_owner_r <= OWN_IF;
            s1_read_r  <= 1'b1;
        end else if (d_gnt_s) begin
            s1_owner_r <= OWN_D;
            s1_read_r  <= ~d_we;
        end else begin
            s1_owner_r <= OWN_NONE;
            s1_read_r  <= 1'b0;
        end
    end

    // Stage 2: route mem_out to the owner; rdata holds between responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            case (s1_owner_r)
                OWN_IF: begin
                    if (s1_read_r) begin
                        if_rvalid_r <= 1'b1;
                        if_rdata_r  <= mem_out;
                    end
                end
                OWN_D: begin
                    if (s1_read_r) begin
                        d_rvalid_r <= 1'b1;
                        d_rdata_r  <= mem_out;
                    end
                end
                default: begin
                    if_rvalid_r <= 1'b0;
                    d_rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt      = if_gnt_s;
    assign d_gnt       = d_gnt_s;
    assign mem_en      = if_gnt_s | d_gnt_s;
    assign mem_r_w     = mem_r_w_s;
    assign mem_address = mem_address_s;
    assign mem_in      = mem_in_s;
    assign if_rvalid   = if_rvalid_r;
    assign d_rvalid    = d_rvalid_r;
    assign if_rdata    = if_rdata_r;
    assign d_rdata     = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, queue-based response model, directed and random stimulus.
// Honours MEM_ARB_RR_EN for the expected conflict policy.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_r_w;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_in;
    logic [DW-1:0] mem_out = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_r_w(mem_r_w), .mem_address(mem_address),
        .mem_in(mem_in), .mem_out(mem_out)
    );

    // Memory instance the DUT drives: read data appears the cycle after the access
    logic [DW-1:0] mem_arr [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_r_w) mem_arr[mem_address[7:0]] <= mem_in;
            else         mem_out <= mem_arr[mem_address[7:0]];
        end
    end

    typedef struct {
        bit            is_if;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    resp_t         rq[$];
    logic [DW-1:0] mdl_mem [0:255];
    int            m_cnt = 0;
`ifdef MEM_ARB_RR_EN
    bit            m_ptr = 1'b0;
`endif
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_d_rdata = '0;
    bit            m_if_gnt = 1'b0;
    bit            m_d_gnt = 1'b0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model and per-cycle comparison of every DUT output
    always @(negedge clk) begin : compare
        bit            e_if, e_d, e_irv, e_drv, e_rw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_in;
        if (!reset) begin
            chk("rst_if_gnt", 32'(if_gnt), 32'd0);
            chk("rst_d_gnt", 32'(d_gnt), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_mem_address", mem_address, 32'd0);
            chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            rq.delete();
            m_cnt = 0;
`ifdef MEM_ARB_RR_EN
            m_ptr = 1'b0;
`endif
            m_if_rdata = '0;
            m_d_rdata = '0;
            m_if_gnt = 1'b0;
            m_d_gnt = 1'b0;
        end else begin
            e_if = 1'b0;
            e_d  = 1'b0;
            if ((m_cnt == WM) && if_req) e_if = 1'b1;
            else if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                e_if = m_ptr;
                e_d  = !m_ptr;
`else
                e_d = 1'b1;
`endif
            end else begin
                e_if = if_req;
                e_d  = d_req;
            end
            e_rw = 1'b0;
            e_addr = '0;
            e_in = '0;
            if (e_if) e_addr = if_addr;
            else if (e_d) begin
                e_rw = d_we;
                e_addr = d_addr;
                e_in = d_wdata;
            end
            e_irv = 1'b0;
            e_drv = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].is_if) begin
                    e_irv = 1'b1;
                    m_if_rdata = rq[0].data;
                end else begin
                    e_drv = 1'b1;
                    m_d_rdata = rq[0].data;
                end
                void'(rq.pop_front());
            end
            chk("if_gnt", 32'(if_gnt), 32'(e_if));
            chk("d_gnt", 32'(d_gnt), 32'(e_d));
            chk("mem_en", 32'(mem_en), 32'(e_if | e_d));
            chk("mem_r_w", 32'(mem_r_w), 32'(e_rw));
            chk("mem_address", mem_address, e_addr);
            chk("mem_in", mem_in, e_in);
            chk("if_rvalid", 32'(if_rvalid), 32'(e_irv));
            chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("d_rdata", d_rdata, m_d_rdata);
            if (e_if) rq.push_back('{1'b1, mdl_mem[if_addr[7:0]], cyc + 2});
            else if (e_d) begin
                if (d_we) mdl_mem[d_addr[7:0]] = d_wdata;
                else rq.push_back('{1'b0, mdl_mem[d_addr[7:0]], cyc + 2});
            end
            if (!if_req || e_if) m_cnt = 0;
            else if (m_cnt < WM) m_cnt++;
`ifdef MEM_ARB_RR_EN
            if (e_if) m_ptr = 1'b0;
            else if (e_d) m_ptr = 1'b1;
`endif
            m_if_gnt = e_if;
            m_d_gnt = e_d;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bit exp_if;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'hC0DE0000 + 32'(i);
            mdl_mem[i] = 32'hC0DE0000 + 32'(i);
        end
        tick();
        tick();
        reset = 1'b1;
        sample();
        chk("post_rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("post_rst_d_rdata", d_rdata, 32'd0);

        // fetch read of 0x10
        tick();
        if_req = 1'b1;
        if_addr = 32'h10;
        sample();
        chk("fetch_gnt", 32'(if_gnt), 32'd1);
        chk("fetch_mem_en", 32'(mem_en), 32'd1);
        chk("fetch_mem_address", mem_address, 32'h10);
        tick();
        if_req = 1'b0;
        sample();
        chk("fetch_rvalid_n1", 32'(if_rvalid), 32'd0);
        tick();
        sample();
        chk("fetch_rvalid_n2", 32'(if_rvalid), 32'd1);
        chk("fetch_rdata", if_rdata, 32'hC0DE0010);
        tick();
        sample();
        chk("fetch_rvalid_n3", 32'(if_rvalid), 32'd0);

        // data write then read of 0x40
        tick();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h40;
        d_wdata = 32'hDEADBEEF;
        sample();
        chk("wr_mem_r_w", 32'(mem_r_w), 32'd1);
        chk("wr_mem_in", mem_in, 32'hDEADBEEF);
        tick();
        d_we = 1'b0;
        sample();
        chk("rd_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0;
        sample();
        chk("wr_no_rvalid", 32'(d_rvalid), 32'd0);
        tick();
        sample();
        chk("rd_rvalid", 32'(d_rvalid), 32'd1);
        chk("rd_rdata", d_rdata, 32'hDEADBEEF);

        // mixed ordering IF@0, D@4, IF@8
        tick();
        if_req = 1'b1;
        if_addr = 32'h0;
        tick();
        if_req = 1'b0;
        d_req = 1'b1;
        d_addr = 32'h4;
        tick();
        d_req = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h8;
        sample();
        chk("mix_if_rdata0", if_rdata, 32'hC0DE0000);
        tick();
        if_req = 1'b0;
        sample();
        chk("mix_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("mix_d_rdata", d_rdata, 32'hC0DE0004);
        tick();
        sample();
        chk("mix_if_rdata8", if_rdata, 32'hC0DE0008);

        // continuous conflict from a fresh reset
        do_reset();
        tick();
        if_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        if_addr = 32'h30;
        d_addr = 32'h34;
        for (int k = 0; k < 10; k++) begin
            sample();
`ifdef MEM_ARB_RR_EN
            exp_if = (k % 2) == 1;
`else
            exp_if = (k % 5) == 4;
`endif
            chk("conflict_if_gnt", 32'(if_gnt), 32'(exp_if));
            chk("conflict_d_gnt", 32'(d_gnt), 32'(!exp_if));
            tick();
        end
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();

        // reset asserted while a read is in flight
        tick();
        if_req = 1'b1;
        if_addr = 32'h20;
        sample();
        chk("mid_gnt", 32'(if_gnt), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_if_rdata", if_rdata, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        if_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("mid_no_rvalid", 32'(if_rvalid | d_rvalid), 32'd0);
            tick();
        end

        // randomized traffic, requesters hold until granted
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!if_req || m_if_gnt) begin
                if_req = ($urandom_range(0, 99) < 60);
                if_addr = {24'h0, 8'($urandom)};
            end
            if (!d_req || m_d_gnt) begin
                d_req = ($urandom_range(0, 99) < 60);
                d_we = 1'($urandom_range(0, 1));
                d_addr = {24'h0, 8'($urandom)};
                d_wdata = $urandom;
            end
        end
        tick();
        if_req = 1'b0;
        d_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port between the core's instruction-fetch path and its load/store path. Both requesters share one `Mem` instance, so at most one access may reach the memory each cycle. The block accepts one request per cycle, drives the memory port, and routes returned read data back to the originating requester through a tagged two-stage response pipeline. An anti-starvation counter guarantees that fetch progresses under continuous data traffic.

## Interface

Parameters:

- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `WAIT_MAX`, 4, consecutive fetch-denied cycles before fetch is forced to win (range 1..15)

Ports:

- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle (combinational)
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_gnt`  out  1  data request accepted this cycle (combinational)
- `d_rvalid`  out  1  data read data valid (reads only)
- `d_rdata`  out  DATA_W  data read data
- `mem_en`  out  1  memory access enable
- `mem_r_w`  out  1  1 = write, 0 = read
- `mem_address`  out  ADDR_W  memory address
- `mem_in`  out  DATA_W  memory write data
- `mem_out`  in  DATA_W  memory read data, valid the cycle after the access

## Operation

- Each cycle, the arbiter grants at most one requester. The grant is a combinational function of `if_req`, `d_req`, the starvation counter and (when configured) the round-robin pointer.
- The mem_* outputs combinationally mirror the granted request. `mem_en` equals `if_gnt | d_gnt`. With no grant, `mem_r_w`, `mem_address` and `mem_in` are 0.
- Fetch is always a read, so `mem_r_w` is 0 on a fetch grant and `mem_in` is 0.
- Default policy is fixed priority: data wins over fetch.
- Starvation counter, 4 bits:
  - Increments each cycle that `if_req` is high and `if_gnt` is low, saturating at `WAIT_MAX`.
  - Clears to 0 when `if_gnt` is high or `if_req` is low.
  - While it equals `WAIT_MAX`, fetch wins over data.
- Response pipeline, per accepted read:
  - Stage 1 registers an owner tag (IF, D or none) and a read flag.
  - Stage 2 registers `mem_out` into the owner's rdata register and asserts that owner's rvalid for exactly one cycle.
- Writes produce no rvalid; for a write, `d_gnt` is the completion.
- The rdata registers hold their last value when rvalid is low.
- A requester must hold its req and payload stable until its gnt. The arbiter does not latch unaccepted requests.

## Timing

- Reset (asynchronous assertion) forces:
  - `if_rvalid`, `d_rvalid`: 0
  - `if_rdata`, `d_rdata`: 0
  - stage tags: none
  - starvation counter: 0
  - round-robin pointer: data
- While reset is low, `if_gnt`, `d_gnt` and `mem_en` are forced to 0.
- Read accepted in cycle N (req and gnt high): memory samples at the end of N, `mem_out` is valid in N+1, and rvalid/rdata are high and valid in N+2. Latency is 2 cycles.
- Throughput is one access per cycle. Back-to-back reads from mixed owners return in issue order, with no bubbles.
- Simultaneous `if_req` and `d_req` resolve per policy. The loser sees gnt low and retries next cycle.
- Reset asserted mid-flight discards all in-flight responses. No rvalid fires after reset is released for requests issued before it.
- Counter saturation: once at `WAIT_MAX`, fetch is granted that cycle whenever `if_req` is high. The counter then returns to 0.

## Configuration

- `MEM_ARB_RR_EN` defined:
  - Round-robin replaces fixed priority.
  - A 1-bit pointer names the preferred requester on a conflict and flips to the other requester after any grant.
  - The starvation counter is still present and still takes precedence.
- Not defined: fixed data-over-fetch priority as described under Operation. The pointer register is absent.

## Test plan

- Fetch read only: `if_req=1`, `if_addr=0x10` in cycle 0 → `if_gnt=1`, `mem_en=1`, `mem_r_w=0`, `mem_address=0x10` in cycle 0; `if_rvalid=1` with `if_rdata=mem[0x10]` in cycle 2 only.
- Data write then read: `d_we=1`, `d_addr=0x40`, `d_wdata=0xDEADBEEF`, then a read of `0x40` → write shows `mem_r_w=1`, `mem_in=0xDEADBEEF` and no `d_rvalid`; the read returns `d_rdata=0xDEADBEEF` two cycles after its grant.
- Conflict, macro off: `if_req` and `d_req` held high continuously with `WAIT_MAX=4` → `d_gnt` for 4 cycles, `if_gnt` on the 5th, then repeating 4:1.
- Conflict, `MEM_ARB_RR_EN` on: both held high → grants alternate D, IF, D, IF…, starting with D after reset.
- Mixed ordering: reads IF `@0x0`, D `@0x4`, IF `@0x8` on consecutive cycles → `if_rvalid`, `d_rvalid`, `if_rvalid` on cycles 2, 3, 4 with the matching data.
- Reset mid-flight: grant a read in cycle 0 and drive `reset` low in cycle 1 → all outputs 0 immediately; no rvalid after reset releases.
